// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer and the control decoder.
// Latency: none (definitions only).
// Backpressure: not applicable.
package fetch_seq_pkg;

  localparam int PC_W_DEF    = 10;
  localparam int INSTR_W_DEF = 9;

  // Opcodes of the 3-bit ISA; decoded by the control decoder, not here.
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_PREP = 3'b101;
  localparam logic [2:0] OP_PSFT = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    EXEC    = 3'd2,
    MEMWAIT = 3'd3,
    HALTED  = 3'd4
  } state_t;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter used for the retired-instruction count.
// Latency: count reflects inc/clr one cycle after they are sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear wins over increment; increment stops at the all-ones value.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute sequencer owning the PC; optional retire counter via FETCH_SEQ_RETIRE_COUNT_EN.
// Latency: one instruction per (fetch latency + 1) cycles, plus MEMWAIT cycles for LW/SW.
// Backpressure: imem_req held until imem_valid; MEMWAIT stalls until dmem_done; no timeouts.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter int              INSTR_W    = INSTR_W_DEF,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               done,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               is_mem_op,
  input  logic               dmem_done,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               halt,
  output logic [PC_W-1:0]    pc,
  output logic [15:0]        instr_count
);

  state_t state;

  // The fetch address is the PC itself; it is only meaningful while imem_req is high.
  assign imem_addr = pc;

  // Sequencer FSM with registered handshake and strobe outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= START_ADDR;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            pc       <= START_ADDR;
            imem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_valid) begin
            state       <= EXEC;
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          // Decoder outputs are valid during the strobe cycle; halt beats everything,
          // and a dmem_done seen here belongs to nobody and is dropped.
          instr_valid <= 1'b0;
          if (halt) begin
            state <= HALTED;
            done  <= 1'b1;
          end else if (is_mem_op) begin
            state <= MEMWAIT;
          end else if (branch_taken) begin
            state    <= FETCH;
            pc       <= branch_target;
            imem_req <= 1'b1;
          end else begin
            state    <= FETCH;
            pc       <= pc + PC_W'(1);
            imem_req <= 1'b1;
          end
        end
        MEMWAIT: begin
          if (dmem_done) begin
            state    <= FETCH;
            pc       <= pc + PC_W'(1);
            imem_req <= 1'b1;
          end
        end
        HALTED: begin
          if (start) begin
            state    <= FETCH;
            pc       <= START_ADDR;
            done     <= 1'b0;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_SEQ_RETIRE_COUNT_EN
  logic retire;
  logic count_clr;

  // An instruction retires leaving EXEC to FETCH, entering HALTED, or leaving MEMWAIT.
  always_comb begin
    retire    = 1'b0;
    count_clr = 1'b0;
    if (state == EXEC && (halt || !is_mem_op)) retire = 1'b1;
    if (state == MEMWAIT && dmem_done) retire = 1'b1;
    if (start && (state == IDLE || state == HALTED)) count_clr = 1'b1;
  end

  sat_counter #(.W(16)) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (count_clr),
    .inc   (retire),
    .count (instr_count)
  );
`else
  assign instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer acting as instruction memory and decoder.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_sequencer;
  import fetch_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [8:0]  imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [8:0]  instr;
  logic        instr_valid;
  logic        is_mem_op = 1'b0;
  logic        dmem_done = 1'b0;
  logic        branch_taken = 1'b0;
  logic [9:0]  branch_target = '0;
  logic        halt = 1'b0;
  logic [9:0]  pc;
  logic [15:0] instr_count;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int last_p0 = 0;
  int exp_cnt = 0;
  logic [9:0] mpc = '0;
  logic [9:0] exp_addr[$];
  logic [8:0] exp_instr[$];

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .done          (done),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .is_mem_op     (is_mem_op),
    .dmem_done     (dmem_done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .pc            (pc),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  // Count execute strobes away from the active edge.
  always @(negedge clk) if (instr_valid === 1'b1) pulses <= pulses + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [5:0] lo);
    return {op, lo};
  endfunction

  task automatic check_count(input string tag);
`ifdef FETCH_SEQ_RETIRE_COUNT_EN
    check(tag, {16'h0, instr_count}, exp_cnt);
`else
    check(tag, {16'h0, instr_count}, 0);
`endif
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cnt = 0;
    exp_addr.push_back(10'h000);
    check("start_done_low", {31'h0, done}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_addr.delete();
    exp_instr.delete();
    exp_cnt = 0;
    check("rst_req", {31'h0, imem_req}, 0);
    check("rst_pc", {22'h0, pc}, 0);
    check("rst_done", {31'h0, done}, 0);
    check("rst_strobe", {31'h0, instr_valid}, 0);
    check("rst_instr", {23'h0, instr}, 0);
    check_count("rst_count");
  endtask

  // Serve one fetch with lat cycles of req; leaves the DUT in its EXEC cycle.
  task automatic do_fetch(input logic [8:0] data, input int lat);
    logic [9:0] ea;
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
    check("req_seen", {31'h0, imem_req}, 1);
    if (exp_addr.size() == 0) begin
      check("sb_addr_nonempty", 0, 1);
      ea = pc;
    end else begin
      ea = exp_addr.pop_front();
    end
    mpc = ea;
    last_p0 = pulses;
    for (int i = 0; i < lat; i++) begin
      check("fetch_req_held", {31'h0, imem_req}, 1);
      check("fetch_addr", {22'h0, imem_addr}, ea);
      if (i == 0 && lat > 1) dmem_done = 1'b1;
      if (i == lat - 1) begin
        imem_valid = 1'b1;
        imem_rdata = data;
        exp_instr.push_back(data);
      end
      tick();
      dmem_done  = 1'b0;
      imem_valid = 1'b0;
      imem_rdata = 9'($urandom);
    end
    check("exec_strobe", {31'h0, instr_valid}, 1);
    if (exp_instr.size() != 0) check("exec_instr", {23'h0, instr}, exp_instr.pop_front());
    check("exec_pc", {22'h0, pc}, mpc);
  endtask

  // Drive decoder outputs in the EXEC cycle; memlat=0 leaves the DUT parked in MEMWAIT.
  task automatic do_exec(input bit h, input bit m, input bit b, input logic [9:0] tgt, input int memlat);
    logic [8:0] cur;
    logic [9:0] nxt;
    cur = instr;
    nxt = mpc + 10'd1;
    halt = h;
    is_mem_op = m;
    branch_taken = b;
    branch_target = tgt;
    dmem_done = m;
    tick();
    halt = 1'b0;
    is_mem_op = 1'b0;
    branch_taken = 1'b0;
    dmem_done = 1'b0;
    check("strobe_one_cycle", {31'h0, instr_valid}, 0);
    check("strobe_pulses", pulses - last_p0, 1);
    if (h) begin
      exp_cnt++;
      check("halt_done", {31'h0, done}, 1);
      check("halt_pc", {22'h0, pc}, mpc);
      check("halt_req", {31'h0, imem_req}, 0);
    end else if (m) begin
      if (memlat == 0) begin
        check("mw_park_req", {31'h0, imem_req}, 0);
      end else begin
        for (int i = 0; i < memlat; i++) begin
          check("mw_req", {31'h0, imem_req}, 0);
          check("mw_instr", {23'h0, instr}, cur);
          if (i == memlat - 1) dmem_done = 1'b1;
          tick();
          dmem_done = 1'b0;
        end
        exp_cnt++;
        exp_addr.push_back(nxt);
      end
    end else begin
      exp_cnt++;
      exp_addr.push_back(b ? tgt : nxt);
    end
    check_count("retire_count");
  endtask

  initial begin
    tick();
    tick();
    do_reset();

    // Straight-line program: three XORs then halt.
    do_start();
    do_fetch(mk(OP_XOR, 6'h01), 1); do_exec(0, 0, 0, 10'h0, 0);
    do_fetch(mk(OP_XOR, 6'h02), 1); do_exec(0, 0, 0, 10'h0, 0);
    do_fetch(mk(OP_XOR, 6'h03), 1); do_exec(0, 0, 0, 10'h0, 0);
    do_fetch(mk(OP_HALT, 6'h00), 1); do_exec(1, 0, 0, 10'h0, 0);
    check("prog_halt_pc", {22'h0, pc}, 3);
    check("prog_done_held", {31'h0, done}, 1);

    // Restart from HALTED, then slow fetch, LW stall, branches, wrap, halt priority.
    do_start();
    do_fetch(mk(OP_BEQ, 6'h05), 1); do_exec(0, 0, 1, 10'h005, 0);
    do_fetch(mk(OP_BEQ, 6'h02), 4); do_exec(0, 0, 1, 10'h002, 0);
    do_fetch(mk(OP_LW, 6'h11), 1);  do_exec(0, 1, 0, 10'h0, 3);
    do_fetch(mk(OP_BEQ, 6'h07), 2); do_exec(0, 0, 1, 10'h007, 0);
    do_fetch(mk(OP_BEQ, 6'h20), 1); do_exec(0, 0, 1, 10'h020, 0);
    do_fetch(mk(OP_BEQ, 6'h07), 1); do_exec(0, 0, 1, 10'h007, 0);
    do_fetch(mk(OP_BEQ, 6'h08), 1); do_exec(0, 0, 0, 10'h020, 0);
    do_fetch(mk(OP_BEQ, 6'h3F), 1); do_exec(0, 0, 1, 10'h3FF, 0);
    do_fetch(mk(OP_ADD, 6'h00), 1); do_exec(0, 0, 0, 10'h0, 0);
    do_fetch(mk(OP_BEQ, 6'h3F), 1); do_exec(0, 0, 1, 10'h3FF, 0);
    do_fetch(mk(OP_HALT, 6'h00), 1); do_exec(1, 0, 1, 10'h020, 0);
    check("halt_beats_branch_pc", {22'h0, pc}, 10'h3FF);

    // Restart, then start ignored in FETCH and reset aborting the fetch.
    do_start();
    do_fetch(mk(OP_SW, 6'h00), 1); do_exec(0, 0, 0, 10'h0, 0);
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fetch_start_ign_req", {31'h0, imem_req}, 1);
    check("fetch_start_ign_addr", {22'h0, imem_addr}, 1);
    do_reset();
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    check("idle_valid_ign_req", {31'h0, imem_req}, 0);
    check("idle_valid_ign_strobe", {31'h0, instr_valid}, 0);

    // Reset while parked in MEMWAIT.
    do_start();
    do_fetch(mk(OP_LW, 6'h05), 1); do_exec(0, 1, 0, 10'h0, 0);
    tick();
    check("mw_still_parked", {31'h0, imem_req}, 0);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle instruction sequencer for the 3-bit-opcode ISA core. Owns the program counter and fetches each instruction over a request/valid handshake with instruction memory. Presents the instruction to the control decoder for one cycle, then stalls on data-memory ops (LW/SW), applies BEQ redirects and stops on halt. Sits between instruction memory and the control decoder / register file.

Parameters:
PC_W, 10, program counter / instruction address width.
INSTR_W, 9, instruction width (opcode in bits [INSTR_W-1:INSTR_W-3], lastBit in bit 0).
START_ADDR, 0, PC loaded on reset and on start.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous active-high reset.
start  in  1  one-cycle pulse; begins execution from START_ADDR when idle or halted.
done  out  1  high while halted.
imem_req  out  1  fetch request, held until imem_valid.
imem_addr  out  PC_W  fetch address, equals pc while imem_req is high.
imem_rdata  in  INSTR_W  fetched instruction, valid with imem_valid.
imem_valid  in  1  fetch complete.
instr  out  INSTR_W  registered instruction to the decoder.
instr_valid  out  1  one-cycle execute strobe.
is_mem_op  in  1  decoder: current instr is LW or SW (DataRead|DataWrite).
dmem_done  in  1  data memory access finished.
branch_taken  in  1  decoder/ALU: BEQ taken.
branch_target  in  PC_W  redirect address.
halt  in  1  decoder: halt instruction.
pc  out  PC_W  current program counter.
instr_count  out  16  retired-instruction count (optional feature).

Behaviour:
- States: IDLE, FETCH, EXEC, MEMWAIT, HALTED. Reset -> IDLE, pc=START_ADDR, instr=0, imem_req=0, instr_valid=0, done=0, instr_count=0. Reset mid-operation aborts any outstanding fetch. imem_req drops in the cycle after the reset edge.
- IDLE: on start -> FETCH, pc=START_ADDR.
- FETCH: imem_req=1, imem_addr=pc. On imem_valid, capture imem_rdata into instr and go to EXEC. Minimum latency is 1 cycle of req. There is no timeout.
- EXEC: instr_valid=1 for exactly this cycle, and decoder inputs are sampled this cycle.
- EXEC priority, highest first: halt -> HALTED, with pc unchanged. Otherwise is_mem_op -> MEMWAIT. Otherwise branch_taken -> pc=branch_target, go to FETCH. Otherwise pc=pc+1, go to FETCH.
- MEMWAIT: hold instr. On dmem_done, pc=pc+1 and go to FETCH. A branch is never taken from MEMWAIT.
- HALTED: done=1. On start -> FETCH, pc=START_ADDR, done=0 on the next cycle.
- pc+1 wraps modulo 2^PC_W: the max address goes to 0.
- Ignored inputs:
  - start outside IDLE/HALTED.
  - imem_valid outside FETCH.
  - dmem_done outside MEMWAIT.
  - dmem_done arriving in the same cycle as the EXEC strobe. MEMWAIT must see it.
- Retire definition: an instruction retires on leaving EXEC to FETCH, on leaving MEMWAIT, and on entering HALTED.
- Throughput: non-memory instruction = fetch latency + 1 cycle. Memory instruction adds MEMWAIT cycles.
- PREP/PSFT prefix state is owned by the decoder. This block treats every opcode uniformly.

Optional Feature:
FETCH_SEQ_RETIRE_COUNT_EN:
- Defined: instr_count increments by 1 per retired instruction and saturates at 16'hFFFF. It is cleared on reset and on start.
- Undefined: instr_count is tied to 0 and no counter flops exist. The port is always present.

Decomposition:
- Package fetch_seq_pkg: state enum (IDLE/FETCH/EXEC/MEMWAIT/HALTED), default PC_W/INSTR_W constants, opcode localparams shared with the decoder.
- Flat module.
- The retire counter, when enabled, is instantiated as sub-module sat_counter (width 16, inc/clr inputs).

Test Plan:
- Reset then start, 1-cycle imem latency, program of 3 XORs then halt -> imem_addr 0,1,2,3; instr_valid pulses 4 times; done=1 with pc=3; instr_count=4 when enabled, 0 otherwise.
- Fetch at pc=5 with imem_valid delayed 4 cycles -> imem_req and imem_addr=5 held stable for 4 cycles; exactly one instr_valid pulse.
- LW at pc=2, dmem_done after 3 cycles -> instr stays in MEMWAIT 3 cycles; next imem_addr=3. A dmem_done pulse during FETCH has no effect.
- BEQ at pc=7 with branch_taken=1, target=10'h020 -> next imem_addr=10'h020. With branch_taken=0 -> next imem_addr=8.
- Edge cases:
  - pc=10'h3FF, non-branch -> next fetch at 0.
  - halt and branch_taken together -> halt wins, pc=10'h3FF.
  - start in HALTED -> refetch from START_ADDR.
- Reset asserted during FETCH and MEMWAIT -> next cycle IDLE, imem_req=0, pc=START_ADDR. start during FETCH is ignored.
